// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache.
// Hits are served combinationally in the same cycle. A miss stalls the CPU and
// runs word-serial writeback/refill bursts over a req/ready handshake.
// Optional feature macro: DCACHE_PERF_EN adds perf_hits/perf_misses counters.
module l1_dcache_ctrl #(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [OFF_W-1:0] beat_q;

    // Line metadata and data storage.
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES][WORDS_PER_LINE];

    // Request decode; the CPU holds the address stable while stalled.
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] cpu_idx;
    logic [OFF_W-1:0] cpu_word;
    logic             req;
    logic             is_write;
    logic             hit;
    logic             last_beat;
    logic             unused_addr_lsbs;

    assign cpu_tag          = cpu_addr[31 -: TAG_W];
    assign cpu_idx          = cpu_addr[IDX_W+OFF_W+1 : OFF_W+2];
    assign cpu_word         = cpu_addr[OFF_W+1 : 2];
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign req       = cpu_rd | cpu_wr;
    assign is_write  = cpu_wr;  // rd and wr together behave as a store
    assign hit       = req & valid_q[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
    assign last_beat = (beat_q == LAST_BEAT);

    // State register and beat counter.
    always_ff @(posedge clock) begin
        // NOTE: state elements use non-blocking assignments so every flop samples
        // the pre-edge values; blocking here would create ordering-dependent races.
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                beat_q <= '0;
            end else if (mem_ready) begin
                beat_q <= last_beat ? '0 : beat_q + OFF_W'(1);
            end
        end
    end

    // Next-state logic plus all CPU and memory-side outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        cpu_stall = 1'b0;
        cpu_rdata = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (!is_write) begin
                            cpu_rdata = data_mem[cpu_idx][cpu_word];
                        end
                    end else begin
                        cpu_stall = 1'b1;
                        state_d   = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[cpu_idx], cpu_idx, beat_q, 2'b00};
                mem_wdata = data_mem[cpu_idx][beat_q];
                if (mem_ready && last_beat) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {cpu_tag, cpu_idx, beat_q, 2'b00};
                if (mem_ready && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid/dirty bookkeeping: store hits dirty a line, bursts clean and validate it.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit && is_write) begin
                        dirty_q[cpu_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready && last_beat) begin
                        dirty_q[cpu_idx] <= 1'b0;
                    end
                end
                REFILL: begin
                    if (mem_ready && last_beat) begin
                        valid_q[cpu_idx] <= 1'b1;
                        dirty_q[cpu_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: byte-merged store hits and word-serial refill beats.
    always_ff @(posedge clock) begin
        // NOTE: tag/data arrays are deliberately not reset; the valid bits gate
        // every use, so clearing them would only cost reset fan-out.
        if (state_q == IDLE && hit && is_write) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_be[b]) begin
                    data_mem[cpu_idx][cpu_word][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
        if (state_q == REFILL && mem_ready) begin
            data_mem[cpu_idx][beat_q] <= mem_rdata;
            if (last_beat) begin
                tag_mem[cpu_idx] <= cpu_tag;
            end
        end
    end

`ifdef DCACHE_PERF_EN
    // Performance counters: one hit per serviced access, one miss per detected miss.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit) begin
                perf_hits <= perf_hits + 32'd1;
            end else begin
                perf_misses <= perf_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// tb_l1_dcache_ctrl: scoreboard bench for l1_dcache_ctrl. Expected memory beats
// are queued before each access and checked as the cache issues them.
`timescale 1ns/1ps
module tb_l1_dcache_ctrl;

    localparam int NUM_LINES      = 64;
    localparam int WORDS_PER_LINE = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    logic        clock;
    logic        reset;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    logic [31:0] bmem [0:4095];
    beat_t       sb [$];
    int          checks_total  = 0;
    int          checks_passed = 0;
    bit          mon_en        = 1'b1;
    bit          bp_mode       = 1'b0;
    int          rdy_cyc       = 0;

    l1_dcache_ctrl #(
        .NUM_LINES     (NUM_LINES),
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
`ifdef DCACHE_PERF_EN
        ,
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    assign mem_rdata = bmem[mem_addr[13:2]];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Backing-memory ready: always high, or 1,0,0,1,0,0,... under backpressure.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            rdy_cyc++;
            mem_ready = bp_mode ? (rdy_cyc % 3 == 0) : 1'b1;
        end
    end

    // Beat monitor: pops the scoreboard per completed beat, models memory writes,
    // and checks that a waiting beat holds its request stable.
    initial begin
        bit          prev_wait = 1'b0;
        logic        prev_we;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        beat_t       exp;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (prev_wait) begin
                    checks_total++;
                    if (mem_req !== 1'b1 || mem_we !== prev_we || mem_addr !== prev_addr ||
                        mem_wdata !== prev_wdata) begin
                        $display("FAIL hold_stable: req=%b we=%b addr=%h wdata=%h, required req=1 we=%b addr=%h wdata=%h",
                                 mem_req, mem_we, mem_addr, mem_wdata, prev_we, prev_addr, prev_wdata);
                    end else begin
                        checks_passed++;
                    end
                end
                if (mem_req && mem_ready) begin
                    checks_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_beat: we=%b addr=%h, required no beat", mem_we, mem_addr);
                    end else begin
                        exp = sb.pop_front();
                        if (mem_we !== exp.we || mem_addr !== exp.addr ||
                            (exp.we && mem_wdata !== exp.wdata)) begin
                            $display("FAIL beat: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, exp.we, exp.addr, exp.wdata);
                        end else begin
                            checks_passed++;
                        end
                    end
                    if (mem_we) bmem[mem_addr[13:2]] = mem_wdata;
                end
                prev_wait  = mem_req && !mem_ready;
                prev_we    = mem_we;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    task automatic push_refill(input logic [31:0] base);
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            sb.push_back('{we: 1'b0, addr: base + 32'(4 * k), wdata: 32'h0});
        end
    endtask

    task automatic push_wb(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        sb.push_back('{we: 1'b1, addr: base,          wdata: w0});
        sb.push_back('{we: 1'b1, addr: base + 32'd4,  wdata: w1});
        sb.push_back('{we: 1'b1, addr: base + 32'd8,  wdata: w2});
        sb.push_back('{we: 1'b1, addr: base + 32'd12, wdata: w3});
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset  = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_be = 4'h0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One CPU access held until the stall drops; exp_stalls < 0 means "at least a clean miss".
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int exp_stalls, input logic [31:0] exp_rdata, input string name);
        int stalls    = 0;
        bit timed_out = 1'b0;
        @(posedge clock);
        #1;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        forever begin
            @(negedge clock);
            if (!cpu_stall) break;
            stalls++;
            if (stalls > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
        checks_total++;
        if (timed_out) begin
            $display("FAIL %s_timeout: stall still high after %0d cycles, required release", name, stalls);
            sb.delete();
        end else if (exp_stalls >= 0 ? (stalls != exp_stalls) : (stalls < 1 + WORDS_PER_LINE)) begin
            $display("FAIL %s_stalls: got %0d, required %0d (negative = at least %0d)",
                     name, stalls, exp_stalls, 1 + WORDS_PER_LINE);
        end else begin
            checks_passed++;
        end
        if (!timed_out && rd && !wr) begin
            checks_total++;
            if (cpu_rdata !== exp_rdata) begin
                $display("FAIL %s_rdata: got %h, required %h", name, cpu_rdata, exp_rdata);
            end else begin
                checks_passed++;
            end
        end
        checks_total++;
        if (sb.size() != 0) begin
            $display("FAIL %s_beats: %0d expected beats never issued, required 0", name, sb.size());
            sb.delete();
        end else begin
            checks_passed++;
        end
        @(posedge clock);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_be = 4'h0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks_total++;
        if ({cpu_stall, mem_req, mem_we} !== 3'b000 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || cpu_rdata !== 32'h0) begin
            $display("FAIL reset_outputs: stall=%b req=%b we=%b addr=%h wdata=%h rdata=%h, required all 0",
                     cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata);
        end else begin
            checks_passed++;
        end
`ifdef DCACHE_PERF_EN
        checks_total++;
        if (perf_hits !== 32'h0 || perf_misses !== 32'h0) begin
            $display("FAIL reset_perf: hits=%0d misses=%0d, required 0/0", perf_hits, perf_misses);
        end else begin
            checks_passed++;
        end
`endif
    endtask

    task automatic test_cold_miss();
        push_refill(32'h100);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1 + WORDS_PER_LINE, 32'hA1, "cold_miss");
        access(1'b1, 1'b0, 32'h10C, 32'h0, 4'h0, 0, 32'hA3, "read_hit");
    endtask

    task automatic test_dirty_evict();
        access(1'b0, 1'b1, 32'h108, 32'hDEADBEEF, 4'hF, 0, 32'h0, "write_hit");
        push_wb(32'h100, 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3);
        push_refill(32'h100 + NUM_LINES * 16);
        access(1'b1, 1'b0, 32'h100 + NUM_LINES * 16, 32'h0, 4'h0, 1 + 2 * WORDS_PER_LINE,
               32'hB0, "dirty_miss");
        checks_total++;
        if (bmem[32'h108 >> 2] !== 32'hDEADBEEF) begin
            $display("FAIL writeback_mem: got %h, required DEADBEEF", bmem[32'h108 >> 2]);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic test_byte_store();
        bmem[32'h104 >> 2] = 32'h11223344;
        push_refill(32'h100);
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1 + WORDS_PER_LINE, 32'h11223344, "byte_fill");
        access(1'b0, 1'b1, 32'h104, 32'h00550000, 4'b0100, 0, 32'h0, "sb_hit");
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h11553344, "sb_read");
        access(1'b1, 1'b1, 32'h100, 32'hCAFE0000, 4'b1100, 0, 32'h0, "rdwr_as_write");
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'hCAFE00A0, "rdwr_read");
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < WORDS_PER_LINE; k++) bmem[(32'h200 >> 2) + k] = 32'hC0 + 32'(k);
        bp_mode = 1'b1;
        push_refill(32'h200);
        access(1'b1, 1'b0, 32'h208, 32'h0, 4'h0, -1, 32'hC2, "backpressure");
        bp_mode = 1'b0;
        access(1'b1, 1'b0, 32'h20C, 32'h0, 4'h0, 0, 32'hC3, "bp_hit");
    endtask

    task automatic test_reset_mid_refill();
        for (int k = 0; k < WORDS_PER_LINE; k++) bmem[(32'h300 >> 2) + k] = 32'hD0 + 32'(k);
        sb.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
        sb.push_back('{we: 1'b0, addr: 32'h304, wdata: 32'h0});
        @(posedge clock);
        #1;
        cpu_rd   = 1'b1;
        cpu_addr = 32'h304;
        @(posedge clock);
        @(posedge clock);
        @(posedge clock);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        cpu_rd = 1'b0;
        checks_total++;
        if (sb.size() != 0) begin
            $display("FAIL mid_refill_beats: %0d of 2 beats missing before reset", sb.size());
            sb.delete();
        end else begin
            checks_passed++;
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks_total++;
        if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            $display("FAIL reset_abandon: req=%b stall=%b, required 0/0", mem_req, cpu_stall);
        end else begin
            checks_passed++;
        end
        mon_en = 1'b1;
        push_refill(32'h300);
        access(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 1 + WORDS_PER_LINE, 32'hD1, "refill_again");
    endtask

`ifdef DCACHE_PERF_EN
    task automatic test_perf();
        do_reset();
        push_refill(32'h100);
        access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1 + WORDS_PER_LINE, bmem[32'h100 >> 2], "perf_m1");
        access(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, bmem[32'h104 >> 2], "perf_h");
        push_refill(32'h100 + NUM_LINES * 16);
        access(1'b1, 1'b0, 32'h100 + NUM_LINES * 16, 32'h0, 4'h0, 1 + WORDS_PER_LINE, 32'hB0, "perf_m2");
        @(negedge clock);
        checks_total++;
        if (perf_hits !== 32'd3 || perf_misses !== 32'd2) begin
            $display("FAIL perf_counts: hits=%0d misses=%0d, required 3/2", perf_hits, perf_misses);
        end else begin
            checks_passed++;
        end
        do_reset();
        @(negedge clock);
        checks_total++;
        if (perf_hits !== 32'h0 || perf_misses !== 32'h0) begin
            $display("FAIL perf_reset: hits=%0d misses=%0d, required 0/0", perf_hits, perf_misses);
        end else begin
            checks_passed++;
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_be    = 4'h0;
        for (int i = 0; i < 4096; i++) bmem[i] = 32'h0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            bmem[(32'h100 >> 2) + k] = 32'hA0 + 32'(k);
            bmem[((32'h100 + NUM_LINES * 16) >> 2) + k] = 32'hB0 + 32'(k);
        end
        test_reset();
        test_cold_miss();
        test_dirty_evict();
        test_byte_store();
        test_backpressure();
        test_reset_mid_refill();
`ifdef DCACHE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
